// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (if / ma) TL-UL style arbiter in front of a single
// slave port. At most one transaction is outstanding. A-channel payload is
// muxed combinationally from the current owner; the D channel is routed back
// to the owner, or a synthesized error response is produced on slave timeout.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternating grants on ties).
module bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  // instruction-fetch master
  input  logic                if_request,
  input  logic                if_a_valid,
  output logic                if_a_ready,
  input  logic [2:0]          if_a_opcode,
  input  logic [2:0]          if_a_size,
  input  logic [ADDR_W-1:0]   if_a_address,
  input  logic [DATA_W/8-1:0] if_a_mask,
  input  logic [DATA_W-1:0]   if_a_data,
  output logic                if_d_valid,
  input  logic                if_d_ready,
  output logic [2:0]          if_d_opcode,
  output logic [DATA_W-1:0]   if_d_data,
  output logic                if_d_error,
  // memory-access master
  input  logic                ma_request,
  input  logic                ma_a_valid,
  output logic                ma_a_ready,
  input  logic [2:0]          ma_a_opcode,
  input  logic [2:0]          ma_a_size,
  input  logic [ADDR_W-1:0]   ma_a_address,
  input  logic [DATA_W/8-1:0] ma_a_mask,
  input  logic [DATA_W-1:0]   ma_a_data,
  output logic                ma_d_valid,
  input  logic                ma_d_ready,
  output logic [2:0]          ma_d_opcode,
  output logic [DATA_W-1:0]   ma_d_data,
  output logic                ma_d_error,
  // slave port
  output logic                mem_a_valid,
  input  logic                mem_a_ready,
  output logic [2:0]          mem_a_opcode,
  output logic [2:0]          mem_a_size,
  output logic [ADDR_W-1:0]   mem_a_address,
  output logic [DATA_W/8-1:0] mem_a_mask,
  output logic [DATA_W-1:0]   mem_a_data,
  input  logic                mem_d_valid,
  input  logic [2:0]          mem_d_opcode,
  input  logic [DATA_W-1:0]   mem_d_data,
  input  logic                mem_d_error,
  output logic                mem_d_ready
);

  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK  = 3'd0;
  localparam logic [2:0] OP_ACCESS_DATA = 3'd1;
  localparam logic [9:0] TIMEOUT_V      = 10'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, RESP, ERR} state_t;

  state_t     state_q;
  logic       owner_q;   // 1 = ma owns the bus, 0 = if
  logic       is_get_q;  // owner's request was a Get (selects error opcode)
  logic [9:0] timer_q;
  logic [9:0] timer_d;

  logic if_pend, ma_pend, grant_ma;
  logic own_d_ready;
  logic rsp_valid, rsp_error;
  logic [2:0] rsp_opcode;
  logic [DATA_W-1:0] rsp_data;
  logic own_a_ready;

  assign if_pend = if_request & if_a_valid;
  assign ma_pend = ma_request & ma_a_valid;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;  // 1 = ma received the most recent grant
  // on a tie, hand the bus to whoever did not get it last time
  assign grant_ma = ma_pend & (~if_pend | ~last_q);
`else
  assign grant_ma = ma_pend;
`endif

  assign own_d_ready = owner_q ? ma_d_ready : if_d_ready;

  // saturating timer increment; never wraps back to zero
  assign timer_d = (timer_q == 10'h3ff) ? timer_q : timer_q + 10'd1;

  // state machine: grant, address phase, response wait, error response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      is_get_q <= 1'b0;
      timer_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (if_pend | ma_pend) begin
            owner_q <= grant_ma;
            state_q <= ADDR;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= grant_ma;
`endif
          end
        end
        ADDR: begin
          if (mem_a_ready) begin
            state_q  <= RESP;
            timer_q  <= '0;
            is_get_q <= (mem_a_opcode == OP_GET);
          end
        end
        RESP: begin
          if (mem_d_valid & own_d_ready) begin
            state_q <= IDLE;
          end else if ((timer_q == TIMEOUT_V) & ~mem_d_valid) begin
            state_q <= ERR;
          end else begin
            timer_q <= timer_d;
          end
        end
        ERR: begin
          if (own_d_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A-channel mux from the owner; payload is passed through, not registered
  always_comb begin
    mem_a_opcode  = owner_q ? ma_a_opcode  : if_a_opcode;
    mem_a_size    = owner_q ? ma_a_size    : if_a_size;
    mem_a_address = owner_q ? ma_a_address : if_a_address;
    mem_a_mask    = owner_q ? ma_a_mask    : if_a_mask;
    mem_a_data    = owner_q ? ma_a_data    : if_a_data;
  end

  // per-state handshake and response decode; reset forces the idle values
  always_comb begin
    mem_a_valid = 1'b0;
    own_a_ready = 1'b0;
    mem_d_ready = 1'b1;  // idle and error states sink stray responses
    rsp_valid   = 1'b0;
    rsp_error   = 1'b0;
    rsp_opcode  = OP_ACCESS_ACK;
    rsp_data    = '0;
    if (!rst) begin
      case (state_q)
        ADDR: begin
          mem_a_valid = 1'b1;
          own_a_ready = mem_a_ready;
          mem_d_ready = 1'b0;
        end
        RESP: begin
          mem_d_ready = own_d_ready;
          rsp_valid   = mem_d_valid;
          rsp_error   = mem_d_error;
          rsp_opcode  = mem_d_opcode;
          rsp_data    = mem_d_data;
        end
        ERR: begin
          rsp_valid  = 1'b1;
          rsp_error  = 1'b1;
          rsp_opcode = is_get_q ? OP_ACCESS_DATA : OP_ACCESS_ACK;
        end
        default: ;
      endcase
    end
  end

  // route handshake and response to the owner only
  always_comb begin
    if_a_ready  = own_a_ready & ~owner_q;
    ma_a_ready  = own_a_ready &  owner_q;
    if_d_valid  = rsp_valid   & ~owner_q;
    ma_d_valid  = rsp_valid   &  owner_q;
    if_d_error  = rsp_error   & ~owner_q;
    ma_d_error  = rsp_error   &  owner_q;
    if_d_opcode = owner_q ? 3'd0 : rsp_opcode;
    ma_d_opcode = owner_q ? rsp_opcode : 3'd0;
    if_d_data   = owner_q ? '0 : rsp_data;
    ma_d_data   = owner_q ? rsp_data : '0;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (default fixed-priority build, TIMEOUT=4).
module tb_bus_arbiter;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  logic if_request, if_a_valid, if_a_ready, if_d_valid, if_d_ready, if_d_error;
  logic [2:0] if_a_opcode, if_a_size, if_d_opcode;
  logic [63:0] if_a_address, if_a_data, if_d_data;
  logic [7:0] if_a_mask;
  logic ma_request, ma_a_valid, ma_a_ready, ma_d_valid, ma_d_ready, ma_d_error;
  logic [2:0] ma_a_opcode, ma_a_size, ma_d_opcode;
  logic [63:0] ma_a_address, ma_a_data, ma_d_data;
  logic [7:0] ma_a_mask;
  logic mem_a_valid, mem_a_ready, mem_d_valid, mem_d_error, mem_d_ready;
  logic [2:0] mem_a_opcode, mem_a_size, mem_d_opcode;
  logic [63:0] mem_a_address, mem_a_data, mem_d_data;
  logic [7:0] mem_a_mask;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
  } a_t;
  typedef struct packed {
    logic        m;
    logic [2:0]  op;
    logic [63:0] data;
    logic        err;
  } d_t;

  a_t exp_a[$];
  d_t exp_d[$];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_request(if_request), .if_a_valid(if_a_valid), .if_a_ready(if_a_ready),
    .if_a_opcode(if_a_opcode), .if_a_size(if_a_size), .if_a_address(if_a_address),
    .if_a_mask(if_a_mask), .if_a_data(if_a_data), .if_d_valid(if_d_valid),
    .if_d_ready(if_d_ready), .if_d_opcode(if_d_opcode), .if_d_data(if_d_data),
    .if_d_error(if_d_error),
    .ma_request(ma_request), .ma_a_valid(ma_a_valid), .ma_a_ready(ma_a_ready),
    .ma_a_opcode(ma_a_opcode), .ma_a_size(ma_a_size), .ma_a_address(ma_a_address),
    .ma_a_mask(ma_a_mask), .ma_a_data(ma_a_data), .ma_d_valid(ma_d_valid),
    .ma_d_ready(ma_d_ready), .ma_d_opcode(ma_d_opcode), .ma_d_data(ma_d_data),
    .ma_d_error(ma_d_error),
    .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready), .mem_a_opcode(mem_a_opcode),
    .mem_a_size(mem_a_size), .mem_a_address(mem_a_address), .mem_a_mask(mem_a_mask),
    .mem_a_data(mem_a_data), .mem_d_valid(mem_d_valid), .mem_d_opcode(mem_d_opcode),
    .mem_d_data(mem_d_data), .mem_d_error(mem_d_error), .mem_d_ready(mem_d_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic check_d(input logic m, input logic [2:0] op, input logic [63:0] data,
                         input logic err);
    d_t e;
    if (exp_d.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL d_unexpected: got response on master %0d data %0h expected none", m, data);
    end else begin
      e = exp_d.pop_front();
      chk("d_master", m, e.m);
      chk("d_opcode", op, e.op);
      chk("d_data", data, e.data);
      chk("d_error", err, e.err);
    end
  endtask

  // monitor: compares every completed handshake against the scoreboard
  always @(negedge clk) begin
    a_t e;
    if (!rst) begin
      if (mem_a_valid && mem_a_ready) begin
        if (exp_a.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL a_unexpected: got A addr %0h expected none", mem_a_address);
        end else begin
          e = exp_a.pop_front();
          chk("a_opcode", mem_a_opcode, e.op);
          chk("a_size", mem_a_size, e.size);
          chk("a_addr", mem_a_address, e.addr);
          chk("a_mask", mem_a_mask, e.mask);
          chk("a_data", mem_a_data, e.data);
        end
      end
      if (if_d_valid && if_d_ready) check_d(1'b0, if_d_opcode, if_d_data, if_d_error);
      if (ma_d_valid && ma_d_ready) check_d(1'b1, ma_d_opcode, ma_d_data, ma_d_error);
    end
  end

  task automatic start_req(input logic m, input logic [2:0] op, input logic [63:0] addr,
                           input logic [7:0] mask, input logic [63:0] data);
    exp_a.push_back('{op: op, size: 3'd3, addr: addr, mask: mask, data: data});
    if (m) begin
      ma_request = 1; ma_a_valid = 1; ma_a_opcode = op; ma_a_size = 3'd3;
      ma_a_address = addr; ma_a_mask = mask; ma_a_data = data;
    end else begin
      if_request = 1; if_a_valid = 1; if_a_opcode = op; if_a_size = 3'd3;
      if_a_address = addr; if_a_mask = mask; if_a_data = data;
    end
  endtask

  task automatic stop_req(input logic m);
    if (m) begin ma_request = 0; ma_a_valid = 0; end
    else   begin if_request = 0; if_a_valid = 0; end
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    #1;
    while (!mem_a_valid && n < 10) begin
      @(posedge clk); #2; n++;
    end
    chk("grant_seen", mem_a_valid, 1);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_mem_a_valid"}, mem_a_valid, 0);
    chk({tag, "_a_ready"}, {if_a_ready, ma_a_ready}, 0);
    chk({tag, "_d_valid"}, {if_d_valid, ma_d_valid}, 0);
    chk({tag, "_d_error"}, {if_d_error, ma_d_error}, 0);
    chk({tag, "_mem_d_ready"}, mem_d_ready, 1);
  endtask

  // slave side of one transaction owned by master m
  task automatic serve(input logic m, input int a_stall, input int resp_delay, input int d_stall,
                       input logic [2:0] dop, input logic [63:0] rdata, input logic rerr,
                       input logic [63:0] exp_addr, output int lat);
    wait_grant(lat);
    for (int i = 0; i < a_stall; i++) begin
      chk("stall_a_valid", mem_a_valid, 1);
      chk("stall_a_addr", mem_a_address, exp_addr);
      chk("stall_a_ready", m ? ma_a_ready : if_a_ready, 0);
      @(posedge clk); #2;
    end
    mem_a_ready = 1;
    #1;
    chk("owner_a_ready", m ? ma_a_ready : if_a_ready, 1);
    chk("other_a_ready", m ? if_a_ready : ma_a_ready, 0);
    @(posedge clk); #1;
    mem_a_ready = 0;
    stop_req(m);
    for (int i = 0; i < resp_delay; i++) begin
      #1;
      chk("wait_d_valid", {if_d_valid, ma_d_valid}, 0);
      @(posedge clk); #1;
    end
    exp_d.push_back('{m: m, op: dop, data: rdata, err: rerr});
    mem_d_valid = 1; mem_d_opcode = dop; mem_d_data = rdata; mem_d_error = rerr;
    if (d_stall > 0) begin
      if (m) ma_d_ready = 0; else if_d_ready = 0;
    end
    #1;
    for (int i = 0; i < d_stall; i++) begin
      chk("stall_mem_d_ready", mem_d_ready, 0);
      chk("stall_d_valid", m ? ma_d_valid : if_d_valid, 1);
      @(posedge clk); #1;
    end
    if (m) ma_d_ready = 1; else if_d_ready = 1;
    #1;
    chk("fwd_mem_d_ready", mem_d_ready, 1);
    chk("fwd_owner_d_valid", m ? ma_d_valid : if_d_valid, 1);
    chk("fwd_other_d_valid", m ? if_d_valid : ma_d_valid, 0);
    @(posedge clk); #1;
    mem_d_valid = 0;
    #1;
    // one mandatory IDLE cycle after the D handshake
    chk("idle_after_d", {mem_a_valid, mem_d_ready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1;
    if_request = 0; if_a_valid = 0; if_a_opcode = 0; if_a_size = 0;
    if_a_address = 0; if_a_mask = 0; if_a_data = 0; if_d_ready = 1;
    ma_request = 0; ma_a_valid = 0; ma_a_opcode = 0; ma_a_size = 0;
    ma_a_address = 0; ma_a_mask = 0; ma_a_data = 0; ma_d_ready = 1;
    mem_a_ready = 0; mem_d_valid = 0; mem_d_opcode = 0; mem_d_data = 0; mem_d_error = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_vals("rst");
    rst = 0;

    // if Get at 0x8000_0000, response 2 cycles after A handshake
    @(posedge clk); #1;
    start_req(1'b0, 3'd4, 64'h8000_0000, 8'hff, 64'h0);
    serve(1'b0, 0, 2, 0, 3'd1, 64'h13, 1'b0, 64'h8000_0000, lat);
    chk("grant_latency", lat, 1);

    // ma PutFullData, immediate AccessAck
    @(posedge clk); #1;
    start_req(1'b1, 3'd0, 64'h1000, 8'hf0, 64'hdead_beef_0123_4567);
    serve(1'b1, 0, 0, 0, 3'd0, 64'h0, 1'b0, 64'h1000, lat);

    // slave-reported error is passed through unchanged
    @(posedge clk); #1;
    start_req(1'b0, 3'd4, 64'h2000, 8'h0f, 64'h0);
    serve(1'b0, 0, 1, 0, 3'd1, 64'h55, 1'b1, 64'h2000, lat);

    // tie: ma first, if after ma's D handshake plus one IDLE cycle
    @(posedge clk); #1;
    start_req(1'b1, 3'd4, 64'h3000, 8'hff, 64'h0);
    start_req(1'b0, 3'd4, 64'h4000, 8'hff, 64'h0);
    serve(1'b1, 0, 0, 0, 3'd1, 64'haaaa, 1'b0, 64'h3000, lat);
    serve(1'b0, 0, 0, 0, 3'd1, 64'hbbbb, 1'b0, 64'h4000, lat);
    chk("tie_second_latency", lat, 1);

    // A-side backpressure 5 cycles, D-side backpressure 3 cycles
    @(posedge clk); #1;
    start_req(1'b1, 3'd1, 64'h5000, 8'h3c, 64'h1111_2222);
    serve(1'b1, 5, 0, 3, 3'd0, 64'h0, 1'b0, 64'h5000, lat);

    // slave never answers: synthesized AccessAckData error for a Get
    @(posedge clk); #1;
    if_d_ready = 0;
    start_req(1'b0, 3'd4, 64'h6000, 8'hff, 64'h0);
    wait_grant(lat);
    mem_a_ready = 1;
    @(posedge clk); #1;
    mem_a_ready = 0;
    stop_req(1'b0);
    exp_d.push_back('{m: 1'b0, op: 3'd1, data: 64'h0, err: 1'b1});
    lat = 0;
    #1;
    while (!if_d_valid && lat < 20) begin
      @(posedge clk); #2; lat++;
    end
    // RESP spans timer values 0..TMO before the error state is entered
    chk("timeout_window", (lat >= TMO && lat <= TMO + 1), 1);
    chk("tmo_d_error", if_d_error, 1);
    chk("tmo_d_data", if_d_data, 0);
    chk("tmo_d_opcode", if_d_opcode, 1);
    chk("tmo_ma_d_valid", ma_d_valid, 0);
    mem_d_valid = 1; mem_d_data = 64'hdead; mem_d_error = 0; mem_d_opcode = 3'd1;
    #1;
    chk("err_mem_d_ready", mem_d_ready, 1);
    chk("err_not_fwd", if_d_data, 0);
    @(posedge clk); #1;
    mem_d_valid = 0;
    #1;
    chk("err_held", if_d_valid, 1);
    if_d_ready = 1;
    @(posedge clk); #1;
    mem_d_valid = 1; mem_d_data = 64'hbeef;
    #1;
    chk("late_mem_d_ready", mem_d_ready, 1);
    chk("late_not_fwd", {if_d_valid, ma_d_valid}, 0);
    @(posedge clk); #1;
    mem_d_valid = 0;

    // reset while waiting for a response aborts the transaction
    @(posedge clk); #1;
    start_req(1'b1, 3'd4, 64'h7000, 8'hff, 64'h0);
    wait_grant(lat);
    mem_a_ready = 1;
    @(posedge clk); #1;
    mem_a_ready = 0;
    stop_req(1'b1);
    #1;
    chk("resp_mem_d_ready", mem_d_ready, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    reset_vals("midrst");
    mem_d_valid = 1; mem_d_data = 64'hbad;
    #1;
    chk("stray_not_fwd", {if_d_valid, ma_d_valid}, 0);
    chk("stray_mem_d_ready", mem_d_ready, 1);
    @(posedge clk); #1;
    mem_d_valid = 0;

    // normal operation resumes after the abort
    @(posedge clk); #1;
    start_req(1'b0, 3'd0, 64'h9000, 8'hff, 64'h77);
    serve(1'b0, 0, 1, 0, 3'd0, 64'h0, 1'b0, 64'h9000, lat);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_a_drained", exp_a.size(), 0);
    chk("exp_d_drained", exp_d.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 ADDR_W, 64, A-channel address width.
REQ-002 DATA_W, 64, A/D data width; mask width is DATA_W/8.
REQ-003 TIMEOUT, 255, maximum RESP cycles before a synthesized error response; range 1..1023.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 if_request / ma_request  input  1  master transaction intent; a master is pending when request and a_valid are both 1.
REQ-007 if_a_valid / ma_a_valid  input  1  A-channel valid per master.
REQ-008 if_a_ready / ma_a_ready  output  1  A-channel ready per master.
REQ-009 if_a_opcode / ma_a_opcode  input  3  TL-UL opcode.
REQ-010 if_a_size / ma_a_size  input  3  log2 of byte count.
REQ-011 if_a_address / ma_a_address  input  ADDR_W  physical address.
REQ-012 if_a_mask / ma_a_mask  input  DATA_W/8  byte lanes.
REQ-013 if_a_data / ma_a_data  input  DATA_W  write data.
REQ-014 if_d_valid / ma_d_valid  output  1  D-channel valid per master.
REQ-015 if_d_ready / ma_d_ready  input  1  D-channel ready per master.
REQ-016 if_d_opcode / ma_d_opcode, if_d_data / ma_d_data, if_d_error / ma_d_error  output  3 / DATA_W / 1  routed response.
REQ-017 mem_a_valid, mem_a_opcode, mem_a_size, mem_a_address, mem_a_mask, mem_a_data  output  1 / 3 / 3 / ADDR_W / DATA_W/8 / DATA_W  merged A channel.
REQ-018 mem_a_ready  input  1  slave A-channel ready.
REQ-019 mem_d_valid, mem_d_opcode, mem_d_data, mem_d_error  input  1 / 3 / DATA_W / 1  slave response.
REQ-020 mem_d_ready  output  1  slave D-channel ready.

Function
REQ-021 States SHALL be IDLE, ADDR, RESP and ERR; one transaction is outstanding at most.
REQ-022 IDLE: if any master is pending, register owner (ma wins ties) and go to ADDR next cycle; otherwise stay in IDLE.
REQ-023 ADDR: mem_a_valid=1 and mem_a_* = owner's A fields (combinational mux); owner a_ready=mem_a_ready; on handshake go to RESP and clear the timer.
REQ-024 Non-owner a_ready and d_valid SHALL be 0 in every state; A payload is not registered, and masters hold fields stable while a_valid=1.
REQ-025 RESP: owner d_* = mem_d_*; mem_d_ready=owner d_ready; on D handshake go to IDLE; otherwise timer+1 per cycle.
REQ-026 RESP with timer==TIMEOUT and no mem_d_valid: go to ERR.
REQ-027 ERR: owner d_valid=1, d_error=1, d_data=0, d_opcode=AccessAckData for Get, else AccessAck; on owner d_ready go to IDLE.
REQ-028 IDLE and ERR: mem_d_ready=1; any mem_d_valid there (late or stray) SHALL be accepted and discarded, never forwarded.
REQ-029 Latency: grant cycle, then A handshake at earliest next cycle, D forwarded same cycle as mem_d_valid; a new grant requires one IDLE cycle (3-cycle minimum per transaction).
REQ-030 Timer SHALL be 10 bits, saturating; it never wraps.

Reset
REQ-031 rst=1 SHALL force IDLE, timer=0, owner=if, last-grant=if, aborting any in-flight transaction.
REQ-032 Output values in reset: all a_ready, d_valid, d_error and mem_a_valid=0; mem_d_ready=1.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN: defined -> on ties grant the master not granted last (last-grant updates on each grant); undefined -> fixed priority, ma always wins ties, no last-grant register.

Verification
REQ-034 if read 0x8000_0000, mem_a_ready=1, mem_d_valid 2 cycles later with data 0x13 -> if_d_valid=1, if_d_data=0x13, ma_d_valid=0, IDLE next cycle.
REQ-035 Both pending same cycle -> ma granted first, if granted after ma D handshake; with ARB_ROUND_ROBIN_EN, three successive ties grant ma, if, ma.
REQ-036 TIMEOUT=4, slave never responds -> owner d_valid=1, d_error=1, d_data=0 after 4 RESP cycles; later mem_d_valid accepted (mem_d_ready=1) and not forwarded.
REQ-037 mem_a_ready low 5 cycles -> mem_a_valid and fields held, owner a_ready=0; owner d_ready low 3 cycles in RESP -> mem_d_ready=0 for those cycles.
REQ-038 rst asserted in RESP -> next cycle IDLE with REQ-032 values; subsequent stray mem_d_valid not forwarded to either master.
